load_store_queue_param: RTL and testbench
=========================================

Name: load_store_queue_param

Overview:
Parametrised in-order load/store queue for the Tomasulo MIPS core. It is the successor to the single-entry LSU.
- Buffers up to DEPTH memory ops in program order.
- Snoops the CDB to wake up pending base and data operands.
- Forms effective address as base + sext(offset).
- Issues one memory request at a time from the head, then reports completion to the ROB/CDB.

Parameters:
DEPTH, 8, entry count; power of two, >= 2
TAG_W, 5, ROB/CDB tag width
DATA_W, 32, data and address width
IMM_W, 16, offset width; sign-extended to DATA_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_en  in  1  enqueue request
issue_ready  out  1  queue can accept (count < DEPTH)
is_store  in  1  1=store, 0=load
rob_tag  in  TAG_W  destination ROB tag
addr_tag  in  TAG_W  producer tag of base register
addr_ready  in  1  base value valid
addr_val  in  DATA_W  base value
offset  in  IMM_W  signed displacement
data_tag  in  TAG_W  producer tag of store data
data_ready  in  1  store data valid (ignored for loads)
data_val  in  DATA_W  store data
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  DATA_W  broadcast value
mem_req  out  1  memory request
mem_we  out  1  1=write
mem_addr  out  DATA_W  effective address
mem_data  out  DATA_W  store data
mem_ack  in  1  memory completion
mem_read_val  in  DATA_W  load data, valid with mem_ack
lsu_done  out  1  one-cycle completion pulse
lsu_tag  out  TAG_W  completing rob_tag
lsu_val  out  DATA_W  load value; 0 for stores
count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - head, tail and count cleared; all entries invalid.
  - FSM goes to IDLE.
  - mem_req, mem_we, lsu_done = 0; mem_addr, mem_data, lsu_tag, lsu_val = 0.
  - Reset mid-transaction drops the outstanding request. A later mem_ack is ignored.
- Enqueue: on issue_en && issue_ready, write entry at tail, tail+1 mod DEPTH, count+1.
  - issue_en while full is ignored; no state change.
  - issue_ready derives from registered count only. There is no same-cycle pop credit.
- Operand capture:
  - Each invalid operand of each valid entry compares cdb_tag when cdb_valid. On a match it takes cdb_data and becomes ready.
  - Same-cycle bypass: if the enqueuing operand is not ready and cdb matches its tag, it is stored ready with cdb_data.
  - Loads mark their data operand ready at enqueue.
- Effective address: base + sext(offset), computed combinationally from the head entry. Wraps modulo 2^DATA_W.
- FSM:
  - IDLE -> REQ when the head entry is valid and all its operands are ready.
  - REQ:
    - mem_req=1; mem_we/mem_addr/mem_data held stable from registers until mem_ack.
    - On mem_ack: capture result, pop head (head+1, count-1), go to DONE.
  - DONE:
    - lsu_done=1 for exactly one cycle, with lsu_tag/lsu_val.
    - Go to IDLE; the next request earliest the following cycle.
  - Latency: ready head -> mem_req = 1 cycle. mem_ack -> lsu_done = 1 cycle.
- Strict program order: no load bypasses an older store.
- mem_ack outside REQ is ignored.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- An entry enqueued when empty, with all operands ready, reaches REQ the next cycle.

Optional Feature:
LSQ_FLUSH_EN
- Defined: adds input port flush (1 bit). flush=1 at posedge invalidates all entries, clears pointers and count, and returns FSM to IDLE. A pending mem_ack is discarded, and lsu_done is suppressed that cycle. flush overrides a simultaneous issue_en.
- Undefined: no flush port; the queue drains only through completion.

Decomposition:
- Package lsq_pkg holds:
  - fsm state enum: IDLE, REQ, DONE.
  - entry struct: valid, is_store, rob_tag, base/tag/ready, offset, data/tag/ready.
  - sext helper function.
- Sub-module lsq_operand_slot: one tag/value/ready register with CDB match, capture and bypass. Instantiated twice per entry.

Test Plan:
- Store, both operands ready: rob_tag=3, base 0x1000, offset -4, data 0xDEADBEEF.
  - mem_req next cycle with mem_we=1, mem_addr=0x0FFC.
  - mem_ack -> lsu_done, tag 3, val 0.
- Load with base pending on tag 7:
  - No mem_req until cdb_valid, tag 7, data 0x200.
  - Then mem_addr = 0x200 + offset 8 = 0x208.
  - mem_read_val 0x55 -> lsu_done, val 0x55.
- Fill DEPTH=8 entries: issue_ready=0 at count 8; a 9th issue_en is ignored. Completing one op frees a slot, and the next issue succeeds.
- Order check: store with data pending, followed by a ready load. The load is not requested until the store completes. Completions arrive in enqueue order.
- Bypass: enqueue with addr_tag=9 not ready, same cycle as cdb tag 9. The entry is captured ready, and mem_req follows the next cycle.
- Reset during REQ, then mem_ack: no lsu_done, count=0, mem_req=0.
- With LSQ_FLUSH_EN defined: flush during REQ gives the same result as reset during REQ.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared types for the parametrised load/store queue: FSM states, entry view and offset sign extension.
package lsq_pkg;

    localparam int unsigned LSQ_TAG_W  = 5;
    localparam int unsigned LSQ_DATA_W = 32;
    localparam int unsigned LSQ_IMM_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsq_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_store;
        logic [LSQ_TAG_W-1:0]  rob_tag;
        logic [LSQ_DATA_W-1:0] base;
        logic [LSQ_TAG_W-1:0]  base_tag;
        logic                  base_ready;
        logic [LSQ_IMM_W-1:0]  offset;
        logic [LSQ_DATA_W-1:0] data;
        logic [LSQ_TAG_W-1:0]  data_tag;
        logic                  data_ready;
    } lsq_entry_t;

    function automatic logic [LSQ_DATA_W-1:0] sext(input logic [LSQ_IMM_W-1:0] imm);
        return {{(LSQ_DATA_W-LSQ_IMM_W){imm[LSQ_IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/lsq_operand_slot.sv
// One operand of a queue entry: tag/value/ready register that wakes up on a matching CDB broadcast,
// including a broadcast that lands in the same cycle the operand is written.
module lsq_operand_slot #(
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              entry_valid,
    input  logic              load,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic              load_ready,
    input  logic [DATA_W-1:0] load_val,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] val,
    output logic              ready
);

    logic hit_new;
    logic hit_held;

    assign hit_new  = cdb_valid && (cdb_tag == load_tag);
    assign hit_held = cdb_valid && entry_valid && !ready && (cdb_tag == tag);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tag   <= '0;
            val   <= '0;
            ready <= 1'b0;
        end else if (load) begin
            tag <= load_tag;
            if (load_ready) begin
                val   <= load_val;
                ready <= 1'b1;
            end else if (hit_new) begin
                val   <= cdb_data;
                ready <= 1'b1;
            end else begin
                val   <= load_val;
                ready <= 1'b0;
            end
        end else if (hit_held) begin
            val   <= cdb_data;
            ready <= 1'b1;
        end
    end

endmodule

// File: rtl/load_store_queue_param.sv
// In-order load/store queue: buffers memory ops, snoops the CDB, issues one request at a time from the head.
// Optional flush port enabled by defining LSQ_FLUSH_EN.
module load_store_queue_param
    import lsq_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = LSQ_TAG_W,
    parameter int unsigned DATA_W = LSQ_DATA_W,
    parameter int unsigned IMM_W  = LSQ_IMM_W
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef LSQ_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         issue_en,
    output logic                         issue_ready,
    input  logic                         is_store,
    input  logic [TAG_W-1:0]             rob_tag,
    input  logic [TAG_W-1:0]             addr_tag,
    input  logic                         addr_ready,
    input  logic [DATA_W-1:0]            addr_val,
    input  logic [IMM_W-1:0]             offset,
    input  logic [TAG_W-1:0]             data_tag,
    input  logic                         data_ready,
    input  logic [DATA_W-1:0]            data_val,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [DATA_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_data,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_read_val,
    output logic                         lsu_done,
    output logic [TAG_W-1:0]             lsu_tag,
    output logic [DATA_W-1:0]            lsu_val,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic                 clear;
    lsq_state_t           state;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     is_store_q;
    logic [TAG_W-1:0]     rob_tag_q [DEPTH];
    logic [IMM_W-1:0]     offset_q  [DEPTH];

    logic [TAG_W-1:0]     base_tag_w  [DEPTH];
    logic [DATA_W-1:0]    base_val_w  [DEPTH];
    logic [DEPTH-1:0]     base_rdy_w;
    logic [TAG_W-1:0]     data_tag_w  [DEPTH];
    logic [DATA_W-1:0]    data_val_w  [DEPTH];
    logic [DEPTH-1:0]     data_rdy_w;

    lsq_entry_t           entries [DEPTH];
    lsq_entry_t           head_e;
    logic                 head_ready;
    logic [DATA_W-1:0]    eff_addr;
    logic                 push;
    logic                 pop;
    logic                 unused_tags;

`ifdef LSQ_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    assign issue_ready = (count != CNT_W'(DEPTH));
    assign push        = issue_en && issue_ready;
    assign pop         = (state == REQ) && mem_ack;

    // Per-entry operand slots; loads have no data dependency, so their data slot is born ready with 0.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic load_here;
        assign load_here = push && (tail == PTR_W'(i));

        lsq_operand_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_base (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear),
            .entry_valid (valid_q[i]),
            .load        (load_here),
            .load_tag    (addr_tag),
            .load_ready  (addr_ready),
            .load_val    (addr_val),
            .cdb_valid   (cdb_valid),
            .cdb_tag     (cdb_tag),
            .cdb_data    (cdb_data),
            .tag         (base_tag_w[i]),
            .val         (base_val_w[i]),
            .ready       (base_rdy_w[i])
        );

        lsq_operand_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_data (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear),
            .entry_valid (valid_q[i]),
            .load        (load_here),
            .load_tag    (data_tag),
            .load_ready  (data_ready || !is_store),
            .load_val    (is_store ? data_val : '0),
            .cdb_valid   (cdb_valid),
            .cdb_tag     (cdb_tag),
            .cdb_data    (cdb_data),
            .tag         (data_tag_w[i]),
            .val         (data_val_w[i]),
            .ready       (data_rdy_w[i])
        );

        always_comb begin
            entries[i]            = '0;
            entries[i].valid      = valid_q[i];
            entries[i].is_store   = is_store_q[i];
            entries[i].rob_tag    = LSQ_TAG_W'(rob_tag_q[i]);
            entries[i].base       = LSQ_DATA_W'(base_val_w[i]);
            entries[i].base_tag   = LSQ_TAG_W'(base_tag_w[i]);
            entries[i].base_ready = base_rdy_w[i];
            entries[i].offset     = LSQ_IMM_W'(offset_q[i]);
            entries[i].data       = LSQ_DATA_W'(data_val_w[i]);
            entries[i].data_tag   = LSQ_TAG_W'(data_tag_w[i]);
            entries[i].data_ready = data_rdy_w[i];
        end
    end

    assign head_e      = entries[head];
    assign head_ready  = head_e.valid && head_e.base_ready && head_e.data_ready;
    assign eff_addr    = DATA_W'(head_e.base + sext(head_e.offset));
    assign unused_tags = ^{head_e.base_tag, head_e.data_tag};

    // Ring pointers, occupancy and per-entry metadata.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                valid_q[tail]    <= 1'b1;
                is_store_q[tail] <= is_store;
                rob_tag_q[tail]  <= rob_tag;
                offset_q[tail]   <= offset;
                tail             <= tail + PTR_W'(1);
            end
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Request sequencer; request payload is frozen in registers for the whole REQ phase.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            lsu_done <= 1'b0;
            lsu_tag  <= '0;
            lsu_val  <= '0;
        end else begin
            lsu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (head_ready) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_we   <= head_e.is_store;
                        mem_addr <= eff_addr;
                        mem_data <= DATA_W'(head_e.data);
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        lsu_done <= 1'b1;
                        lsu_tag  <= TAG_W'(head_e.rob_tag);
                        lsu_val  <= head_e.is_store ? '0 : mem_read_val;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_queue_param.sv
// Directed scoreboard bench for load_store_queue_param; covers the flush port when LSQ_FLUSH_EN is defined.
module tb_load_store_queue_param;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        issue_en;
    logic        issue_ready;
    logic        is_store;
    logic [4:0]  rob_tag;
    logic [4:0]  addr_tag;
    logic        addr_ready;
    logic [31:0] addr_val;
    logic [15:0] offset;
    logic [4:0]  data_tag;
    logic        data_ready;
    logic [31:0] data_val;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic [31:0] mem_read_val;
    logic        lsu_done;
    logic [4:0]  lsu_tag;
    logic [31:0] lsu_val;
    logic [3:0]  count;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] val;
    } done_t;

    req_t  exp_req[$];
    done_t exp_done[$];
    req_t  mon_req;
    done_t mon_done;
    logic  req_seen;
    int    n_checks;
    int    n_fail;

    load_store_queue_param #(.DEPTH(8), .TAG_W(5), .DATA_W(32), .IMM_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef LSQ_FLUSH_EN
        .flush        (flush),
`endif
        .issue_en     (issue_en),
        .issue_ready  (issue_ready),
        .is_store     (is_store),
        .rob_tag      (rob_tag),
        .addr_tag     (addr_tag),
        .addr_ready   (addr_ready),
        .addr_val     (addr_val),
        .offset       (offset),
        .data_tag     (data_tag),
        .data_ready   (data_ready),
        .data_val     (data_val),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ack      (mem_ack),
        .mem_read_val (mem_read_val),
        .lsu_done     (lsu_done),
        .lsu_tag      (lsu_tag),
        .lsu_val      (lsu_val),
        .count        (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every new request and every completion is matched against the scoreboard queues.
    always @(negedge clk) begin
        if (mem_req === 1'b1 && !req_seen) begin
            req_seen = 1'b1;
            if (exp_req.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_unexpected: got request addr 0x%0h, expected none", mem_addr);
            end else begin
                mon_req = exp_req.pop_front();
                check("req_we",   64'(mem_we),   64'(mon_req.we));
                check("req_addr", 64'(mem_addr), 64'(mon_req.addr));
                check("req_data", 64'(mem_data), 64'(mon_req.data));
            end
        end
        if (mem_req !== 1'b1) req_seen = 1'b0;
        if (lsu_done === 1'b1) begin
            if (exp_done.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_unexpected: got lsu_done tag %0d, expected none", lsu_tag);
            end else begin
                mon_done = exp_done.pop_front();
                check("done_tag", 64'(lsu_tag), 64'(mon_done.tag));
                check("done_val", 64'(lsu_val), 64'(mon_done.val));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic exp_r(input logic we, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.we = we; r.addr = a; r.data = d;
        exp_req.push_back(r);
    endtask

    task automatic exp_d(input logic [4:0] t, input logic [31:0] v);
        done_t e;
        e.tag = t; e.val = v;
        exp_done.push_back(e);
    endtask

    task automatic set_issue(input logic st, input logic [4:0] tag, input logic [4:0] at, input logic ar,
                             input logic [31:0] av, input logic [15:0] off, input logic [4:0] dt,
                             input logic dr, input logic [31:0] dv);
        issue_en = 1'b1; is_store = st; rob_tag = tag;
        addr_tag = at; addr_ready = ar; addr_val = av; offset = off;
        data_tag = dt; data_ready = dr; data_val = dv;
    endtask

    task automatic issue(input logic st, input logic [4:0] tag, input logic [4:0] at, input logic ar,
                         input logic [31:0] av, input logic [15:0] off, input logic [4:0] dt,
                         input logic dr, input logic [31:0] dv);
        set_issue(st, tag, at, ar, av, off, dt, dr, dv);
        step();
        issue_en = 1'b0;
    endtask

    task automatic broadcast(input logic [4:0] t, input logic [31:0] d);
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
        step();
        cdb_valid = 1'b0;
    endtask

    task automatic wait_req();
        for (int k = 0; k < 30 && mem_req !== 1'b1; k++) step();
        check("wait_req", 64'(mem_req), 64'(1));
    endtask

    task automatic ack(input logic [31:0] v);
        mem_ack = 1'b1; mem_read_val = v;
        step();
        mem_ack = 1'b0; mem_read_val = '0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; req_seen = 1'b0;
        rst = 1'b1; flush = 1'b0; issue_en = 1'b0; is_store = 1'b0; rob_tag = '0;
        addr_tag = '0; addr_ready = 1'b0; addr_val = '0; offset = '0;
        data_tag = '0; data_ready = 1'b0; data_val = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; mem_ack = 1'b0; mem_read_val = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_count",    64'(count),       64'(0));
        check("rst_ready",    64'(issue_ready), 64'(1));
        check("rst_mem_req",  64'(mem_req),     64'(0));
        check("rst_done",     64'(lsu_done),    64'(0));
        check("rst_mem_addr", 64'(mem_addr),    64'(0));
        check("rst_lsu_tag",  64'(lsu_tag),     64'(0));

        // Ready store: request one cycle after enqueue, EA = 0x1000 - 4
        exp_r(1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF);
        exp_d(5'd3, 32'h0);
        issue(1'b1, 5'd3, 5'd0, 1'b1, 32'h1000, 16'hFFFC, 5'd0, 1'b1, 32'hDEAD_BEEF);
        check("st_count",    64'(count),   64'(1));
        check("st_req_lat0", 64'(mem_req), 64'(0));
        step();
        check("st_req_lat1", 64'(mem_req), 64'(1));
        step();
        check("st_req_hold", 64'(mem_addr), 64'(32'h0FFC));
        ack(32'h1234_5678);
        check("st_done",     64'(lsu_done), 64'(1));
        check("st_count0",   64'(count),    64'(0));
        step();
        check("st_done_pls", 64'(lsu_done), 64'(0));

        // Load with base pending on tag 7; wrong-tag broadcast must not wake it
        exp_r(1'b0, 32'h0000_0208, 32'h0);
        exp_d(5'd4, 32'h55);
        issue(1'b0, 5'd4, 5'd7, 1'b0, 32'h0, 16'h0008, 5'd0, 1'b0, 32'hFFFF_FFFF);
        broadcast(5'd6, 32'h9000);
        step();
        check("ld_wait", 64'(mem_req), 64'(0));
        broadcast(5'd7, 32'h200);
        check("ld_wake0", 64'(mem_req), 64'(0));
        step();
        check("ld_wake1", 64'(mem_req), 64'(1));
        ack(32'h55);
        step();

        // Fill all 8 entries behind a pending base, then overflow attempt
        for (int i = 0; i < 8; i++) begin
            exp_r(1'b0, 32'h3000 + 32'(i * 4), 32'h0);
            exp_d(5'(8 + i), 32'h100 + 32'(i));
            issue(1'b0, 5'(8 + i), 5'd20, 1'b0, 32'h0, 16'(i * 4), 5'd0, 1'b0, 32'h0);
        end
        check("full_count", 64'(count),       64'(8));
        check("full_ready", 64'(issue_ready), 64'(0));
        issue(1'b0, 5'd31, 5'd0, 1'b1, 32'h9999, 16'h0, 5'd0, 1'b0, 32'h0);
        check("full_ignore", 64'(count),   64'(8));
        check("full_noreq",  64'(mem_req), 64'(0));
        broadcast(5'd20, 32'h3000);
        wait_req();
        ack(32'h100);
        check("pop_count", 64'(count),       64'(7));
        check("pop_ready", 64'(issue_ready), 64'(1));

        // Enqueue and pop on the same edge: occupancy unchanged
        wait_req();
        exp_r(1'b0, 32'h4000, 32'h0);
        exp_d(5'd16, 32'h4444);
        set_issue(1'b0, 5'd16, 5'd0, 1'b1, 32'h4000, 16'h0, 5'd0, 1'b0, 32'h0);
        mem_ack = 1'b1; mem_read_val = 32'h101;
        step();
        issue_en = 1'b0; mem_ack = 1'b0; mem_read_val = '0;
        check("pushpop_count", 64'(count), 64'(7));
        for (int i = 2; i < 8; i++) begin
            wait_req();
            ack(32'h100 + 32'(i));
        end
        wait_req();
        ack(32'h4444);
        check("drain_count", 64'(count), 64'(0));
        step();

        // Order: a ready load waits behind a store whose data is pending
        exp_r(1'b1, 32'h100, 32'hCAFE);
        exp_d(5'd1, 32'h0);
        exp_r(1'b0, 32'h500, 32'h0);
        exp_d(5'd2, 32'h77);
        issue(1'b1, 5'd1, 5'd0, 1'b1, 32'h100, 16'h0, 5'd12, 1'b0, 32'h0);
        issue(1'b0, 5'd2, 5'd0, 1'b1, 32'h500, 16'h0, 5'd0, 1'b0, 32'h0);
        step(); step();
        check("order_block", 64'(mem_req), 64'(0));
        broadcast(5'd12, 32'hCAFE);
        wait_req();
        ack(32'h0);
        wait_req();
        ack(32'h77);
        step();

        // Same-cycle bypass at enqueue
        exp_r(1'b0, 32'h810, 32'h0);
        exp_d(5'd5, 32'h99);
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'h800;
        issue(1'b0, 5'd5, 5'd9, 1'b0, 32'h0, 16'h0010, 5'd0, 1'b0, 32'h0);
        cdb_valid = 1'b0;
        check("byp_lat0", 64'(mem_req), 64'(0));
        step();
        check("byp_lat1", 64'(mem_req), 64'(1));
        ack(32'h99);
        step();

        // Reset mid-request; the late ack must be dropped
        exp_r(1'b1, 32'h40, 32'h11);
        issue(1'b1, 5'd6, 5'd0, 1'b1, 32'h40, 16'h0, 5'd0, 1'b1, 32'h11);
        step();
        check("rreq_req", 64'(mem_req), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        ack(32'hABCD);
        check("rreq_done",  64'(lsu_done),    64'(0));
        check("rreq_count", 64'(count),       64'(0));
        check("rreq_mreq",  64'(mem_req),     64'(0));
        check("rreq_ready", 64'(issue_ready), 64'(1));
        step();
        check("rreq_done2", 64'(lsu_done), 64'(0));

`ifdef LSQ_FLUSH_EN
        // Flush mid-request, then flush overriding an enqueue
        exp_r(1'b1, 32'h44, 32'h22);
        issue(1'b1, 5'd7, 5'd0, 1'b1, 32'h44, 16'h0, 5'd0, 1'b1, 32'h22);
        step();
        check("fl_req", 64'(mem_req), 64'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        ack(32'hABCD);
        check("fl_done",  64'(lsu_done), 64'(0));
        check("fl_count", 64'(count),    64'(0));
        check("fl_mreq",  64'(mem_req),  64'(0));
        flush = 1'b1;
        issue(1'b0, 5'd8, 5'd0, 1'b1, 32'h60, 16'h0, 5'd0, 1'b0, 32'h0);
        flush = 1'b0;
        check("fl_issue_count", 64'(count), 64'(0));
        step();
        check("fl_issue_noreq", 64'(mem_req), 64'(0));
`endif

        step();
        check("sb_req_empty",  64'(exp_req.size()),  64'(0));
        check("sb_done_empty", 64'(exp_done.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
